// File: rtl/count_seq_if.sv
// Command/status bundle between a host sequencer and count_seq_ctrl.
interface count_seq_if #(
  parameter int WIDTH = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic             cmd_mode;
  logic [WIDTH-1:0] qout;
  logic             tc_pulse;
  logic             busy;
  logic             done;

  modport master (
    output cmd_valid, cmd_op, cmd_data, cmd_mode,
    input  cmd_ready, qout, tc_pulse, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, cmd_mode,
    output cmd_ready, qout, tc_pulse, busy, done
  );
endinterface

// File: rtl/count_seq_ctrl.sv
// Command-driven up-counter sequencer (load/start/pause/stop, one-shot or periodic).
// Optional tick prescaler enabled by defining COUNT_SEQ_PRESCALE_EN.
//
// state   | meaning
// S_IDLE  | stopped, count cleared, waiting for START
// S_RUN   | counting one step per tick toward limit
// S_PAUSE | count frozen, START resumes, STOP returns to idle
// S_DONE  | one-shot reached limit, count held at limit
module count_seq_ctrl #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 4
) (
  input  logic        clk,
  input  logic        reset,
  count_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_START = 2'b01;
  localparam logic [1:0] OP_STOP  = 2'b10;
  localparam logic [1:0] OP_LOAD  = 2'b11;

  if (PRESCALE < 1 || PRESCALE > 255) begin : g_bad_prescale
    $error("count_seq_ctrl: PRESCALE must be in 1..255");
  end

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_qout, w_qout_nxt;
  logic [WIDTH-1:0] r_limit, w_limit_nxt;
  logic             r_mode, w_mode_nxt;
  logic             r_tc, w_tc_nxt;
  logic             r_cmd_ready;
  logic             w_accept;
  logic             w_cmd_act;
  logic             w_tick;
  logic             w_pre_tc;
  logic             w_pre_clr;

  assign w_accept  = bus.cmd_valid && r_cmd_ready;
  // An accepted NOP leaves the tick alone; any real command steals it.
  assign w_cmd_act = w_accept && (bus.cmd_op != OP_NOP);
  assign w_tick    = (r_state == S_RUN) && !w_cmd_act && w_pre_tc;

`ifdef COUNT_SEQ_PRESCALE_EN
  localparam logic [7:0] PRE_LOAD = 8'(PRESCALE - 1);

  logic [7:0] r_pre_cnt;

  assign w_pre_tc = (r_pre_cnt == 8'd0);

  // Down-counter reloads on terminal count; frozen outside RUN so PAUSE keeps phase.
  always_ff @(posedge clk) begin
    if (reset || w_pre_clr) begin
      r_pre_cnt <= PRE_LOAD;
    end else if (r_state == S_RUN) begin
      if (r_pre_cnt == 8'd0) r_pre_cnt <= PRE_LOAD;
      else                   r_pre_cnt <= r_pre_cnt - 8'd1;
    end
  end
`else
  assign w_pre_tc = 1'b1;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_qout_nxt  = r_qout;
    w_limit_nxt = r_limit;
    w_mode_nxt  = r_mode;
    w_tc_nxt    = 1'b0;
    w_pre_clr   = 1'b0;

    if (w_accept) begin
      case (bus.cmd_op)
        OP_START: begin
          if (r_state == S_IDLE || r_state == S_DONE) begin
            w_qout_nxt  = '0;
            w_mode_nxt  = bus.cmd_mode;
            w_state_nxt = S_RUN;
            w_pre_clr   = 1'b1;
          end else if (r_state == S_PAUSE) begin
            w_state_nxt = S_RUN;
          end
        end
        OP_STOP: begin
          if (r_state == S_RUN) begin
            w_state_nxt = S_PAUSE;
          end else if (r_state == S_PAUSE) begin
            w_state_nxt = S_IDLE;
            w_qout_nxt  = '0;
          end
        end
        OP_LOAD: begin
          w_limit_nxt = bus.cmd_data;
          if (r_state != S_RUN) w_qout_nxt = '0;
          if (r_state == S_DONE) w_state_nxt = S_IDLE;
        end
        default: ;
      endcase
    end

    if (w_tick) begin
      if (r_qout == r_limit) begin
        w_tc_nxt = 1'b1;
        if (r_mode) w_qout_nxt  = '0;
        else        w_state_nxt = S_DONE;
      end else begin
        // Wraps modulo 2^WIDTH when a RUN-time LOAD dropped limit below qout.
        w_qout_nxt = r_qout + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_qout      <= '0;
      r_limit     <= '1;
      r_mode      <= 1'b0;
      r_tc        <= 1'b0;
      r_cmd_ready <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_qout      <= w_qout_nxt;
      r_limit     <= w_limit_nxt;
      r_mode      <= w_mode_nxt;
      r_tc        <= w_tc_nxt;
      r_cmd_ready <= !w_accept;
    end
  end

  assign bus.cmd_ready = r_cmd_ready;
  assign bus.qout      = r_qout;
  assign bus.tc_pulse  = r_tc;
  assign bus.busy      = (r_state == S_RUN) || (r_state == S_PAUSE);
  assign bus.done      = (r_state == S_DONE);

endmodule

// File: doc/count_seq_ctrl.md
Name: count_seq_ctrl

Overview:
- Command-driven controller that sequences a free-running up-counter datapath: load terminal value, start, pause/resume, stop.
- Supports one-shot and periodic (auto-reload) modes; flags terminal count.
- Sits between a host/sequencer command interface and the counter datapath; owns the count register.

Parameters:
- WIDTH, 8: counter and terminal-value width.
- PRESCALE, 4: clocks per count tick. Used only with COUNT_SEQ_PRESCALE_EN. Legal range 1..255.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high; overrides all other inputs.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  controller accepts the command this cycle.
- cmd_op  input  2  00 NOP, 01 START, 10 STOP, 11 LOAD.
- cmd_data  input  WIDTH  terminal value for LOAD.
- cmd_mode  input  1  sampled on START: 0 one-shot, 1 periodic.
- qout  output  WIDTH  current count.
- tc_pulse  output  1  one-cycle terminal-count strobe.
- busy  output  1  high in RUN or PAUSE.
- done  output  1  high in DONE.

Behaviour:
- Reset values: state IDLE, qout=0, limit=all-ones (255), mode_q=0, tc_pulse=0, done=0, busy=0, cmd_ready=1.
- Handshake:
  - A command is accepted when cmd_valid && cmd_ready at a posedge.
  - cmd_ready drops for exactly the one cycle following each accepted command.
  - Commands presented while cmd_ready=0 are ignored. The requester must hold them.
  - An accepted NOP has no effect.
- FSM states: IDLE, RUN, PAUSE, DONE.
- START:
  - From IDLE or DONE: qout<=0, mode_q<=cmd_mode, go RUN.
  - From PAUSE: resume RUN; qout and mode_q unchanged.
  - In RUN: no effect.
- STOP:
  - RUN -> PAUSE, qout held.
  - PAUSE -> IDLE, qout<=0.
  - IDLE/DONE: no effect.
- LOAD:
  - limit<=cmd_data in any state.
  - In IDLE/DONE/PAUSE: also qout<=0. DONE -> IDLE.
  - In RUN: qout unchanged; new limit applies from the next compare.
- RUN, per tick (every clk when the macro is off):
  - If qout==limit: tc_pulse<=1.
    - Periodic: qout<=0, stay RUN.
    - One-shot: qout holds at limit, go DONE.
  - Else qout<=qout+1.
- tc_pulse is registered: high for exactly one cycle after the terminal edge. It is 0 otherwise.
- Latency: START accepted at edge N gives RUN from N; qout=1 after N+1. With limit L, the terminal compare fires at edge N+L+1.
- Boundary cases:
  - limit=0, periodic: tc_pulse every tick; qout stays 0.
  - limit=0, one-shot: DONE at first tick.
  - qout never exceeds limit, so there is no natural wrap. If a LOAD in RUN sets limit below the current qout, qout keeps counting to all-ones, wraps to 0 modulo 2^WIDTH, then hits the new limit.
  - An accepted command in the same cycle as a tick has priority. The tick is suppressed: no increment and no tc_pulse that cycle.
- Reset mid-RUN or mid-PAUSE returns to reset values on the next edge. No tc_pulse is emitted.
- Outputs: busy and done are decoded from the registered state.

Optional Feature:
- Macro COUNT_SEQ_PRESCALE_EN.
- With the macro:
  - An internal prescaler generates a tick every PRESCALE clocks while in RUN.
  - The prescaler clears on START from IDLE/DONE and on reset. It is held (not cleared) in PAUSE.
  - With PRESCALE=1, behaviour is identical to macro-off.
- Without the macro: tick=1 every clock in RUN; PRESCALE is ignored; no prescaler logic.

Test Plan:
- Reset for 2 cycles, then idle -> qout=0, tc_pulse=0, busy=0, done=0, cmd_ready=1; first LOAD accepted and cmd_ready=0 the next cycle.
- LOAD 5, START mode=0 -> qout 1,2,3,4,5 on consecutive cycles; tc_pulse one cycle; done=1; qout stays 5; further clocks change nothing.
- LOAD 3, START mode=1 for 16 cycles -> qout sequence 1,2,3,0,1,2,3,0...; tc_pulse period exactly 4 cycles; done never set.
- LOAD 10, START, STOP when qout=4 -> PAUSE, qout holds 4 for 5 cycles; START -> resumes 5,6...; second STOP then STOP -> IDLE with qout=0.
- Periodic run with limit 7; LOAD 2 when qout=5 -> qout counts 6..255, 0,1,2 then tc_pulse; subsequent period 3 cycles.
- Reset asserted while RUN at qout=9 -> next edge qout=0, IDLE, no tc_pulse. With COUNT_SEQ_PRESCALE_EN and PRESCALE=4: LOAD 2, START mode=0 -> qout increments every 4th clock, DONE after 12 clocks.
